// File: rtl/flag_branch_unit_pkg.sv
// Shared constants for the EX-stage flag register and branch resolver:
// branch opcode, condition codes, flag bit positions and FSM state type.
package flag_branch_unit_pkg;

    localparam logic [3:0] OP_B = 4'hC;

    localparam logic [2:0] COND_NE = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_GT = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_LE = 3'b101;
    localparam logic [2:0] COND_OV = 3'b110;
    localparam logic [2:0] COND_UN = 3'b111;

    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic {
        IDLE,
        REDIRECT
    } brState_t;

    function automatic logic isBranch(input logic [15:0] instr);
        return instr[15:12] == OP_B;
    endfunction

endpackage

// File: rtl/flag_branch_unit_cond.sv
// Combinational branch condition evaluator: (cond, {V,Z,N}) -> taken.
module branch_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic flagV;
    logic flagZ;
    logic flagN;

    assign flagV = flags[FLAG_V];
    assign flagZ = flags[FLAG_Z];
    assign flagN = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_NE: taken = ~flagZ;
            COND_EQ: taken = flagZ;
            COND_GT: taken = ~flagZ & ~flagN;
            COND_LT: taken = flagN;
            COND_GE: taken = flagZ | ~flagN;
            COND_LE: taken = flagZ | flagN;
            COND_OV: taken = flagV;
            COND_UN: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// EX-stage flag register, branch resolution and one-cycle redirect/flush FSM.
// Optional BRANCH_STATS_EN adds saturating branch/taken counters.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned OFF_W = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            stall,
    input  logic [15:0]     instr,
    input  logic [PC_W-1:0] pc_plus1,
    input  logic            alu_V,
    input  logic            alu_Z,
    input  logic            alu_N,
    output logic [2:0]      flags,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush_if,
    output logic            flush_id,
    output logic            ex_kill
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     br_count,
    output logic [15:0]     br_taken
`endif
);

    brState_t        state;
    logic            live;
    logic            liveBranch;
    logic            condTaken;
    logic [PC_W-1:0] offsetExt;
    logic [PC_W-1:0] target;

    // ex_kill is high throughout REDIRECT, so wrong-path EX work is never live.
    assign live       = ex_valid & ~stall & ~ex_kill;
    assign liveBranch = live & isBranch(instr);

    branch_cond_eval uCondEval (
        .cond  (instr[11:9]),
        .flags (flags),
        .taken (condTaken)
    );

    assign offsetExt = {{(PC_W-OFF_W){instr[OFF_W-1]}}, instr[OFF_W-1:0]};
    assign target    = pc_plus1 + offsetExt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 3'b000;
        end else if (live) begin
            flags <= {alu_V, alu_Z, alu_N};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            flush_if    <= 1'b0;
            flush_id    <= 1'b0;
            ex_kill     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (liveBranch && condTaken) begin
                        state       <= REDIRECT;
                        redirect    <= 1'b1;
                        redirect_pc <= target;
                        flush_if    <= 1'b1;
                        flush_id    <= 1'b1;
                        ex_kill     <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (!stall) begin
                        state       <= IDLE;
                        redirect    <= 1'b0;
                        redirect_pc <= '0;
                        flush_if    <= 1'b0;
                        flush_id    <= 1'b0;
                        ex_kill     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count <= 16'h0000;
            br_taken <= 16'h0000;
        end else if (liveBranch) begin
            if (br_count != 16'hFFFF) br_count <= br_count + 16'h0001;
            if (condTaken && br_taken != 16'hFFFF) br_taken <= br_taken + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed scoreboard bench for flag_branch_unit (honours BRANCH_STATS_EN).
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [15:0] pc_plus1 = 16'h0000;
    logic        alu_V = 1'b0;
    logic        alu_Z = 1'b0;
    logic        alu_N = 1'b0;
    logic [2:0]  flags;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic        ex_kill;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_count;
    logic [15:0] br_taken;
`endif

    int checks = 0;
    int errors = 0;
    int expCount = 0;
    int expTaken = 0;

    typedef struct {
        string       tag;
        logic [2:0]  flags;
        logic        redir;
        logic [15:0] rpc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    flag_branch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .stall       (stall),
        .instr       (instr),
        .pc_plus1    (pc_plus1),
        .alu_V       (alu_V),
        .alu_Z       (alu_Z),
        .alu_N       (alu_N),
        .flags       (flags),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .ex_kill     (ex_kill)
`ifdef BRANCH_STATS_EN
        ,
        .br_count    (br_count),
        .br_taken    (br_taken)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mkB(input logic [2:0] cond, input logic [8:0] off);
        return {4'hC, cond, off};
    endfunction

    // Drive one cycle, push the expected post-edge state, then pop and compare.
    task automatic step(input string tag, input logic valid, input logic stl,
                        input logic [15:0] ins, input logic [15:0] pc,
                        input logic [2:0] alu, input logic [2:0] expFlags,
                        input logic expRedir, input logic [15:0] expPc);
        exp_t e;
        ex_valid = valid;
        stall    = stl;
        instr    = ins;
        pc_plus1 = pc;
        {alu_V, alu_Z, alu_N} = alu;
        sb.push_back('{tag: tag, flags: expFlags, redir: expRedir, rpc: expPc});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_flags"}, {29'd0, flags}, {29'd0, e.flags});
            chk({e.tag, "_redirect"}, {31'd0, redirect}, {31'd0, e.redir});
            chk({e.tag, "_redirect_pc"}, {16'd0, redirect_pc}, {16'd0, e.rpc});
            chk({e.tag, "_flush_if"}, {31'd0, flush_if}, {31'd0, e.redir});
            chk({e.tag, "_flush_id"}, {31'd0, flush_id}, {31'd0, e.redir});
            chk({e.tag, "_ex_kill"}, {31'd0, ex_kill}, {31'd0, e.redir});
        end
    endtask

    localparam logic [15:0] ADD = 16'h0123;

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk("rst_flags", {29'd0, flags}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_redirect_pc", {16'd0, redirect_pc}, 32'd0);
        chk("rst_ex_kill", {31'd0, ex_kill}, 32'd0);
        rst = 1'b0;

        // Flag capture, and hold under stall
        step("cap_add",   1, 0, ADD, 16'h0001, 3'b101, 3'b101, 0, 16'h0000);
        step("cap_stall", 1, 1, ADD, 16'h0002, 3'b010, 3'b101, 0, 16'h0000);
        step("cap_inval", 0, 0, ADD, 16'h0002, 3'b010, 3'b101, 0, 16'h0000);
        step("set_z",     1, 0, ADD, 16'h0003, 3'b010, 3'b010, 0, 16'h0000);

        // Taken EQ with negative offset, then back to idle
        step("eq_taken", 1, 0, mkB(3'b001, 9'h1F0), 16'h0010, 3'b010, 3'b010, 1, 16'h0000);
        expCount++; expTaken++;
        step("eq_ret",   0, 0, ADD, 16'h0011, 3'b000, 3'b010, 0, 16'h0000);

        // NE not taken while Z=1
        step("ne_nt",    1, 0, mkB(3'b000, 9'h010), 16'h0020, 3'b010, 3'b010, 0, 16'h0000);
        expCount++;

        // Flags 000: LE not taken, GT taken
        step("clr",      1, 0, ADD, 16'h0030, 3'b000, 3'b000, 0, 16'h0000);
        step("le_nt",    1, 0, mkB(3'b101, 9'h005), 16'h0100, 3'b000, 3'b000, 0, 16'h0000);
        expCount++;
        step("gt_taken", 1, 0, mkB(3'b010, 9'h005), 16'h0100, 3'b000, 3'b000, 1, 16'h0105);
        expCount++; expTaken++;
        step("gt_ret",   0, 0, ADD, 16'h0101, 3'b000, 3'b000, 0, 16'h0000);

        // OV with V=1 and LT with N=1
        step("set_vn",   1, 0, ADD, 16'h0200, 3'b101, 3'b101, 0, 16'h0000);
        step("ov_taken", 1, 0, mkB(3'b110, 9'h0FF), 16'h0200, 3'b101, 3'b101, 1, 16'h02FF);
        expCount++; expTaken++;
        step("ov_ret",   0, 0, ADD, 16'h0201, 3'b000, 3'b101, 0, 16'h0000);
        step("lt_taken", 1, 0, mkB(3'b011, 9'h100), 16'h0300, 3'b101, 3'b101, 1, 16'h0200);
        expCount++; expTaken++;
        step("lt_ret",   0, 0, ADD, 16'h0301, 3'b000, 3'b101, 0, 16'h0000);
        step("ge_nt",    1, 0, mkB(3'b100, 9'h001), 16'h0300, 3'b101, 3'b101, 0, 16'h0000);
        expCount++;

        // Wrap-around target, then stall held three cycles in REDIRECT
        step("wrap",     1, 0, mkB(3'b111, 9'h002), 16'hFFFF, 3'b000, 3'b000, 1, 16'h0001);
        expCount++; expTaken++;
        step("stall1",   1, 1, ADD, 16'h0002, 3'b111, 3'b000, 1, 16'h0001);
        step("stall2",   1, 1, ADD, 16'h0002, 3'b111, 3'b000, 1, 16'h0001);
        step("stall3",   1, 1, ADD, 16'h0002, 3'b111, 3'b000, 1, 16'h0001);
        step("stall_ret", 0, 0, ADD, 16'h0002, 3'b111, 3'b000, 0, 16'h0000);

        // Wrong-path branch during REDIRECT is ignored, flags not written
        step("wp_first", 1, 0, mkB(3'b111, 9'h010), 16'h0020, 3'b000, 3'b000, 1, 16'h0030);
        expCount++; expTaken++;
        step("wp_second", 1, 0, mkB(3'b111, 9'h001), 16'h0040, 3'b111, 3'b000, 0, 16'h0000);
        step("wp_after", 0, 0, ADD, 16'h0041, 3'b111, 3'b000, 0, 16'h0000);

        // Stall in IDLE defers evaluation to first unstalled cycle
        step("idle_stall", 1, 1, mkB(3'b111, 9'h004), 16'h0050, 3'b011, 3'b000, 0, 16'h0000);
        step("idle_go",  1, 0, mkB(3'b111, 9'h004), 16'h0050, 3'b011, 3'b011, 1, 16'h0054);
        expCount++; expTaken++;
        step("idle_ret", 0, 0, ADD, 16'h0051, 3'b000, 3'b011, 0, 16'h0000);

`ifdef BRANCH_STATS_EN
        chk("br_count", {16'd0, br_count}, expCount);
        chk("br_taken", {16'd0, br_taken}, expTaken);
`endif

        // Async reset in the middle of REDIRECT
        step("pre_rst_f", 1, 0, ADD, 16'h0060, 3'b111, 3'b111, 0, 16'h0000);
        step("pre_rst_b", 1, 0, mkB(3'b111, 9'h008), 16'h0060, 3'b111, 3'b111, 1, 16'h0068);
        ex_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_flags", {29'd0, flags}, 32'd0);
        chk("arst_redirect", {31'd0, redirect}, 32'd0);
        chk("arst_redirect_pc", {16'd0, redirect_pc}, 32'd0);
        chk("arst_flush_if", {31'd0, flush_if}, 32'd0);
        chk("arst_flush_id", {31'd0, flush_id}, 32'd0);
        chk("arst_ex_kill", {31'd0, ex_kill}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("arst_br_count", {16'd0, br_count}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 0, 0, ADD, 16'h0070, 3'b000, 3'b000, 0, 16'h0000);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
